vec_inst_issue_unit: RTL and testbench

Scalar-side issue unit for vector instructions. It accepts vector instructions and their scalar operands from the scalar pipeline, buffers them in an in-order FIFO, and hands them to the vector processor over a valid/ready handshake. It tracks in-flight instructions and serializes configuration instructions (vsetvli/vsetivli/vsetvl), returning the resulting vl to the scalar register file.

---
 rtl/vec_issue_pkg.sv | 37 +++
 rtl/vec_issue_fifo.sv | 41 ++++
 rtl/vec_inst_issue_unit.sv | 139 +++++++++++++
 tb/tb_vec_inst_issue_unit.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_issue_pkg.sv
// Shared types and opcode helpers for the vector instruction issue unit.
// Entries carry the decoded config flag so the FSM never re-decodes the head.
package vec_issue_pkg;

    localparam int unsigned VXLEN = 32;

    typedef enum logic [6:0] {
        V_LOAD  = 7'h07,
        V_STORE = 7'h27,
        V_ARITH = 7'h57
    } v_opcode_e;

    localparam logic [2:0] CFG_FUNC3 = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CFG_WAIT,
        WB
    } issue_state_e;

    typedef struct packed {
        logic [VXLEN-1:0] word;
        logic [VXLEN-1:0] rs1;
        logic [VXLEN-1:0] rs2;
        logic             is_cfg;
    } issue_entry_t;

    function automatic logic is_vec_opcode(input logic [6:0] op);
        return (op == V_ARITH) || (op == V_LOAD) || (op == V_STORE);
    endfunction

    function automatic logic is_cfg_inst(input logic [6:0] op, input logic [2:0] f3);
        return (op == V_ARITH) && (f3 == CFG_FUNC3);
    endfunction

endpackage

// File: rtl/vec_issue_fifo.sv
// In-order synchronous FIFO with async reset; head is the current read entry.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module vec_issue_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/vec_inst_issue_unit.sv
// Buffers vector instructions from the scalar pipeline and issues them in order,
// draining in-flight work around config instructions and writing the new vl back.
module vec_inst_issue_unit
    import vec_issue_pkg::*;
#(
    parameter int unsigned XLEN    = VXLEN,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inst_valid,
    input  logic [XLEN-1:0] inst,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            inst_ready,
    output logic            illegal_inst,
    output logic            vec_inst_valid,
    output logic [XLEN-1:0] vec_inst,
    output logic [XLEN-1:0] vec_rs1_data,
    output logic [XLEN-1:0] vec_rs2_data,
    input  logic            vec_inst_ready,
    input  logic            vec_done,
    input  logic [XLEN-1:0] vec_rd_data,
    output logic            scalar_wb_valid,
    output logic [4:0]      scalar_wb_addr,
    output logic [XLEN-1:0] scalar_wb_data,
    output logic            cfg_pending
);

    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    issue_entry_t    push_entry;
    issue_entry_t    head_entry;
    logic            full, empty;
    logic            accept, push, pop, done_ok;
    logic [OW-1:0]   out_q, out_d;
    logic [CW-1:0]   cfg_cnt_q, cfg_cnt_d;
    issue_state_e    state_q, state_d;
    logic [4:0]      cfg_rd_q;
    logic            illegal_q;
    logic [4:0]      wb_addr_q;
    logic [XLEN-1:0] wb_data_q;

    assign inst_ready = !full;
    assign accept     = inst_valid && inst_ready;
    assign push       = accept && is_vec_opcode(inst[6:0]);
    assign pop        = vec_inst_valid && vec_inst_ready;
    // Completions with nothing outstanding (e.g. stale ones after reset) are dropped.
    assign done_ok    = vec_done && (out_q != '0);

    assign push_entry = '{word: inst, rs1: rs1_data, rs2: rs2_data,
                          is_cfg: is_cfg_inst(inst[6:0], inst[14:12])};

    vec_issue_fifo #(
        .WIDTH($bits(issue_entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .head     (head_entry),
        .full     (full),
        .empty    (empty)
    );

    assign vec_inst        = empty ? '0 : head_entry.word;
    assign vec_rs1_data    = empty ? '0 : head_entry.rs1;
    assign vec_rs2_data    = empty ? '0 : head_entry.rs2;
    assign illegal_inst    = illegal_q;
    assign scalar_wb_addr  = wb_addr_q;
    assign scalar_wb_data  = wb_data_q;
    assign cfg_pending     = (cfg_cnt_q != '0) || (state_q != IDLE);

    always_comb begin
        out_d = out_q;
        if (pop && !done_ok)      out_d = out_q + OW'(1);
        else if (!pop && done_ok) out_d = out_q - OW'(1);

        cfg_cnt_d = cfg_cnt_q;
        if ((push && push_entry.is_cfg) && !(pop && head_entry.is_cfg)) begin
            cfg_cnt_d = cfg_cnt_q + CW'(1);
        end else if (!(push && push_entry.is_cfg) && (pop && head_entry.is_cfg)) begin
            cfg_cnt_d = cfg_cnt_q - CW'(1);
        end
    end

    always_comb begin
        state_d         = state_q;
        vec_inst_valid  = 1'b0;
        scalar_wb_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (head_entry.is_cfg) state_d = DRAIN;
                    else                   vec_inst_valid = (out_q < OW'(MAX_OUT));
                end
            end
            DRAIN: begin
                vec_inst_valid = (out_q == '0);
                if (pop) state_d = CFG_WAIT;
            end
            CFG_WAIT: begin
                if (done_ok) state_d = (cfg_rd_q != 5'd0) ? WB : IDLE;
            end
            WB: begin
                scalar_wb_valid = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            out_q     <= '0;
            cfg_cnt_q <= '0;
            cfg_rd_q  <= '0;
            illegal_q <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            cfg_cnt_q <= cfg_cnt_d;
            illegal_q <= accept && !is_vec_opcode(inst[6:0]);
            if (pop && (state_q == DRAIN)) cfg_rd_q <= head_entry.word[11:7];
            if ((state_q == CFG_WAIT) && done_ok) begin
                wb_addr_q <= cfg_rd_q;
                wb_data_q <= vec_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_vec_inst_issue_unit.sv
// Directed scenarios plus a randomized run against a transaction-level model.
module tb_vec_inst_issue_unit;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic [31:0] inst, rs1_data, rs2_data;
    logic        inst_ready, illegal_inst;
    logic        vec_inst_valid;
    logic [31:0] vec_inst, vec_rs1_data, vec_rs2_data;
    logic        vec_inst_ready, vec_done;
    logic [31:0] vec_rd_data;
    logic        scalar_wb_valid;
    logic [4:0]  scalar_wb_addr;
    logic [31:0] scalar_wb_data;
    logic        cfg_pending;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vec_inst_issue_unit #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk            (clk),
        .reset          (reset),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .inst_ready     (inst_ready),
        .illegal_inst   (illegal_inst),
        .vec_inst_valid (vec_inst_valid),
        .vec_inst       (vec_inst),
        .vec_rs1_data   (vec_rs1_data),
        .vec_rs2_data   (vec_rs2_data),
        .vec_inst_ready (vec_inst_ready),
        .vec_done       (vec_done),
        .vec_rd_data    (vec_rd_data),
        .scalar_wb_valid(scalar_wb_valid),
        .scalar_wb_addr (scalar_wb_addr),
        .scalar_wb_data (scalar_wb_data),
        .cfg_pending    (cfg_pending)
    );

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [4:0] rd);
        logic [31:0] w;
        w        = $urandom;
        w[6:0]   = op;
        w[11:7]  = rd;
        w[14:12] = f3;
        return w;
    endfunction

    function automatic bit is_vec(input logic [31:0] w);
        return (w[6:0] == 7'h57) || (w[6:0] == 7'h07) || (w[6:0] == 7'h27);
    endfunction

    function automatic bit is_cfg(input logic [31:0] w);
        return (w[6:0] == 7'h57) && (w[14:12] == 3'b111);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_valid = 0; inst = 0; rs1_data = 0; rs2_data = 0;
        vec_inst_ready = 0; vec_done = 0; vec_rd_data = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        #2;
        tests++;
        if ({inst_ready, illegal_inst, vec_inst_valid, scalar_wb_valid, cfg_pending} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 10000",
                     {inst_ready, illegal_inst, vec_inst_valid, scalar_wb_valid, cfg_pending});
        end
        tests++;
        if ({vec_inst, vec_rs1_data, vec_rs2_data} !== 96'd0) begin
            fails++;
            $display("FAIL reset_data: got %h expected 0", {vec_inst, vec_rs1_data, vec_rs2_data});
        end
        tests++;
        if ({scalar_wb_addr, scalar_wb_data} !== 37'd0) begin
            fails++;
            $display("FAIL reset_wb: got %h expected 0", {scalar_wb_addr, scalar_wb_data});
        end
        tick();
        reset = 0;
    endtask

    task automatic test_load_issue();
        logic [31:0] w [5];
        do_reset();
        for (int i = 0; i < 5; i++) w[i] = mk(7'h07, 3'($urandom), 5'($urandom));
        vec_inst_ready = 1;
        inst_valid = 1; inst = w[0];
        @(negedge clk);
        tests++;
        if (vec_inst_valid !== 1'b0) begin
            fails++; $display("FAIL load_no_bypass: got %b expected 0", vec_inst_valid);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            inst = w[i+1];
            @(negedge clk);
            tests++;
            if (vec_inst_valid !== 1'b1 || vec_inst !== w[i]) begin
                fails++;
                $display("FAIL load_issue[%0d]: got v=%b %h expected v=1 %h",
                         i, vec_inst_valid, vec_inst, w[i]);
            end
            tick();
        end
        inst_valid = 0;
        @(negedge clk);
        tests++;
        if (vec_inst_valid !== 1'b0) begin
            fails++; $display("FAIL load_max_out: got %b expected 0", vec_inst_valid);
        end
        tick();
        vec_done = 1;
        tick();
        vec_done = 0;
        @(negedge clk);
        tests++;
        if (vec_inst_valid !== 1'b1 || vec_inst !== w[4]) begin
            fails++;
            $display("FAIL load_after_done: got v=%b %h expected v=1 %h",
                     vec_inst_valid, vec_inst, w[4]);
        end
        tick();
    endtask

    task automatic test_fifo_full();
        logic [31:0] a [5];
        logic [31:0] r1 [5];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            a[i]  = mk(7'h57, 3'($urandom_range(0, 6)), 5'($urandom));
            r1[i] = $urandom;
        end
        for (int k = 0; k < 5; k++) begin
            inst_valid = 1; inst = a[k]; rs1_data = r1[k];
            @(negedge clk);
            tests++;
            if (inst_ready !== (k < 4)) begin
                fails++; $display("FAIL full_ready[%0d]: got %b expected %b", k, inst_ready, k < 4);
            end
            if (k >= 1) begin
                tests++;
                if (vec_inst_valid !== 1'b1 || vec_inst !== a[0]) begin
                    fails++;
                    $display("FAIL full_stable[%0d]: got v=%b %h expected v=1 %h",
                             k, vec_inst_valid, vec_inst, a[0]);
                end
            end
            tick();
        end
        vec_inst_ready = 1; vec_done = 1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            tests++;
            if (vec_inst_valid !== 1'b1 || vec_inst !== a[j] || vec_rs1_data !== r1[j]) begin
                fails++;
                $display("FAIL full_drain[%0d]: got v=%b %h/%h expected v=1 %h/%h",
                         j, vec_inst_valid, vec_inst, vec_rs1_data, a[j], r1[j]);
            end
            if (j < 2) begin
                tests++;
                if (inst_ready !== (j == 1)) begin
                    fails++;
                    $display("FAIL full_pop_ready[%0d]: got %b expected %b", j, inst_ready, j == 1);
                end
            end
            tick();
            if (j == 1) inst_valid = 0;
        end
    endtask

    task automatic test_cfg_drain();
        logic [31:0] c;
        do_reset();
        c = mk(7'h57, 3'b111, 5'd5);
        vec_inst_ready = 1;
        inst_valid = 1; inst = mk(7'h07, 3'd2, 5'd1);
        tick();
        inst = mk(7'h07, 3'd2, 5'd2);
        tick();
        inst = c;
        tick();
        inst_valid = 0;
        for (int i = 0; i < 4; i++) begin
            vec_done = (i >= 2);
            @(negedge clk);
            tests++;
            if (vec_inst_valid !== 1'b0 || cfg_pending !== 1'b1) begin
                fails++;
                $display("FAIL cfg_drain_hold[%0d]: got v=%b pend=%b expected v=0 pend=1",
                         i, vec_inst_valid, cfg_pending);
            end
            tick();
        end
        vec_done = 0;
        @(negedge clk);
        tests++;
        if (vec_inst_valid !== 1'b1 || vec_inst !== c) begin
            fails++;
            $display("FAIL cfg_issue: got v=%b %h expected v=1 %h", vec_inst_valid, vec_inst, c);
        end
        tick();
        vec_done = 1; vec_rd_data = 32'd16;
        @(negedge clk);
        tests++;
        if (vec_inst_valid !== 1'b0 || scalar_wb_valid !== 1'b0) begin
            fails++;
            $display("FAIL cfg_wait: got v=%b wb=%b expected 0 0", vec_inst_valid, scalar_wb_valid);
        end
        tick();
        vec_done = 0; vec_rd_data = 0;
        @(negedge clk);
        tests++;
        if (scalar_wb_valid !== 1'b1 || scalar_wb_addr !== 5'd5 || scalar_wb_data !== 32'd16) begin
            fails++;
            $display("FAIL cfg_wb: got %b/%0d/%0d expected 1/5/16",
                     scalar_wb_valid, scalar_wb_addr, scalar_wb_data);
        end
        tick();
        @(negedge clk);
        tests++;
        if (scalar_wb_valid !== 1'b0 || cfg_pending !== 1'b0) begin
            fails++;
            $display("FAIL cfg_after_wb: got wb=%b pend=%b expected 0 0", scalar_wb_valid, cfg_pending);
        end
        tick();
    endtask

    task automatic test_cfg_rd0();
        logic [31:0] c;
        do_reset();
        c = mk(7'h57, 3'b111, 5'd0);
        vec_inst_ready = 1;
        inst_valid = 1; inst = c;
        tick();
        inst_valid = 0;
        @(negedge clk);
        tests++;
        if (vec_inst_valid !== 1'b0 || cfg_pending !== 1'b1) begin
            fails++;
            $display("FAIL rd0_bubble: got v=%b pend=%b expected 0 1", vec_inst_valid, cfg_pending);
        end
        tick();
        @(negedge clk);
        tests++;
        if (vec_inst_valid !== 1'b1 || vec_inst !== c) begin
            fails++;
            $display("FAIL rd0_issue: got v=%b %h expected v=1 %h", vec_inst_valid, vec_inst, c);
        end
        tick();
        vec_done = 1; vec_rd_data = 32'd9;
        tick();
        vec_done = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (scalar_wb_valid !== 1'b0 || cfg_pending !== 1'b0) begin
                fails++;
                $display("FAIL rd0_no_wb[%0d]: got wb=%b pend=%b expected 0 0",
                         i, scalar_wb_valid, cfg_pending);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        do_reset();
        vec_inst_ready = 1;
        inst_valid = 1; inst = mk(7'h33, 3'd0, 5'd3);
        @(negedge clk);
        tests++;
        if (illegal_inst !== 1'b0) begin
            fails++; $display("FAIL illegal_early: got %b expected 0", illegal_inst);
        end
        tick();
        inst_valid = 0;
        @(negedge clk);
        tests++;
        if (illegal_inst !== 1'b1 || vec_inst_valid !== 1'b0) begin
            fails++;
            $display("FAIL illegal_pulse: got ill=%b v=%b expected 1 0", illegal_inst, vec_inst_valid);
        end
        tick();
        @(negedge clk);
        tests++;
        if ({illegal_inst, vec_inst_valid, cfg_pending, inst_ready} !== 4'b0001) begin
            fails++;
            $display("FAIL illegal_after: got %b expected 0001",
                     {illegal_inst, vec_inst_valid, cfg_pending, inst_ready});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] l;
        do_reset();
        vec_inst_ready = 1;
        inst_valid = 1; inst = mk(7'h57, 3'b111, 5'd7);
        tick();
        inst = mk(7'h07, 3'd0, 5'd1);
        tick();
        inst = mk(7'h27, 3'd0, 5'd2);
        tick();
        inst_valid = 0;
        @(negedge clk);
        tests++;
        if (vec_inst_valid !== 1'b0 || cfg_pending !== 1'b1) begin
            fails++;
            $display("FAIL mid_cfg_wait: got v=%b pend=%b expected 0 1", vec_inst_valid, cfg_pending);
        end
        #1 reset = 1;
        #1;
        tests++;
        if ({inst_ready, illegal_inst, vec_inst_valid, scalar_wb_valid, cfg_pending} !== 5'b10000 ||
            vec_inst !== 32'd0 || scalar_wb_addr !== 5'd0 || scalar_wb_data !== 32'd0) begin
            fails++;
            $display("FAIL mid_reset_vals: got ctrl=%b inst=%h wb=%0d/%0d expected 10000 0 0/0",
                     {inst_ready, illegal_inst, vec_inst_valid, scalar_wb_valid, cfg_pending},
                     vec_inst, scalar_wb_addr, scalar_wb_data);
        end
        tick();
        reset = 0;
        vec_done = 1; vec_rd_data = 32'd33;
        tick();
        vec_done = 0;
        l = mk(7'h07, 3'd1, 5'd4);
        inst_valid = 1; inst = l;
        @(negedge clk);
        tests++;
        if (scalar_wb_valid !== 1'b0 || cfg_pending !== 1'b0) begin
            fails++;
            $display("FAIL mid_stale_done: got wb=%b pend=%b expected 0 0", scalar_wb_valid, cfg_pending);
        end
        tick();
        inst_valid = 0;
        @(negedge clk);
        tests++;
        if (vec_inst_valid !== 1'b1 || vec_inst !== l) begin
            fails++;
            $display("FAIL mid_no_underflow: got v=%b %h expected v=1 %h", vec_inst_valid, vec_inst, l);
        end
        tick();
    endtask

    typedef struct {
        logic [31:0] word;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } ent_t;

    task automatic test_random();
        ent_t        mq [$];
        ent_t        e;
        int          m_out = 0;
        bit          m_busy = 0, m_inflight = 0, m_drain = 0, m_wb = 0, m_ill = 0;
        logic [4:0]  m_rd = 0, m_wb_addr = 0;
        logic [31:0] m_wb_data = 0;
        bit          head_cfg, exp_valid, exp_pend, issue, accept, done_ok;
        int          r;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            inst_valid = ($urandom_range(0, 2) != 0);
            if (r < 3)      inst = mk(7'h07, 3'($urandom), 5'($urandom));
            else if (r < 4) inst = mk(7'h27, 3'($urandom), 5'($urandom));
            else if (r < 7) inst = mk(7'h57, 3'($urandom_range(0, 6)), 5'($urandom));
            else if (r < 9) inst = mk(7'h57, 3'b111, 5'($urandom_range(0, 3)));
            else            inst = mk(7'h33, 3'($urandom), 5'($urandom));
            rs1_data = $urandom; rs2_data = $urandom;
            vec_inst_ready = ($urandom_range(0, 3) != 0);
            vec_done = ($urandom_range(0, 2) == 0);
            vec_rd_data = $urandom;
            @(negedge clk);
            head_cfg = (mq.size() > 0) && is_cfg(mq[0].word);
            exp_pend = m_busy;
            foreach (mq[i]) if (is_cfg(mq[i].word)) exp_pend = 1;
            exp_valid = (mq.size() > 0) && !m_busy &&
                        (head_cfg ? (m_drain && m_out == 0) : (m_out < MAX_OUT));
            tests++;
            if (vec_inst_valid !== exp_valid) begin
                fails++; $display("FAIL rnd_valid@%0d: got %b expected %b", n, vec_inst_valid, exp_valid);
            end
            if (exp_valid) begin
                tests++;
                if ({vec_inst, vec_rs1_data, vec_rs2_data} !== {mq[0].word, mq[0].rs1, mq[0].rs2}) begin
                    fails++;
                    $display("FAIL rnd_head@%0d: got %h expected %h", n,
                             {vec_inst, vec_rs1_data, vec_rs2_data}, {mq[0].word, mq[0].rs1, mq[0].rs2});
                end
            end
            tests++;
            if (inst_ready !== (mq.size() < DEPTH)) begin
                fails++; $display("FAIL rnd_ready@%0d: got %b expected %b", n, inst_ready, mq.size() < DEPTH);
            end
            tests++;
            if (illegal_inst !== m_ill || cfg_pending !== exp_pend || scalar_wb_valid !== m_wb) begin
                fails++;
                $display("FAIL rnd_status@%0d: got ill=%b pend=%b wb=%b expected %b %b %b", n,
                         illegal_inst, cfg_pending, scalar_wb_valid, m_ill, exp_pend, m_wb);
            end
            if (m_wb) begin
                tests++;
                if (scalar_wb_addr !== m_wb_addr || scalar_wb_data !== m_wb_data) begin
                    fails++;
                    $display("FAIL rnd_wb@%0d: got %0d/%h expected %0d/%h", n,
                             scalar_wb_addr, scalar_wb_data, m_wb_addr, m_wb_data);
                end
            end
            // Advance the model across the coming clock edge.
            issue   = exp_valid && vec_inst_ready;
            accept  = inst_valid && (mq.size() < DEPTH);
            done_ok = vec_done && (m_out > 0);
            if (!m_busy && head_cfg && !m_drain) m_drain = 1;
            if (m_wb) begin
                m_wb = 0; m_busy = 0;
            end else if (m_inflight && done_ok) begin
                m_inflight = 0;
                if (m_rd != 0) begin
                    m_wb = 1; m_wb_addr = m_rd; m_wb_data = vec_rd_data;
                end else begin
                    m_busy = 0;
                end
            end
            if (issue) begin
                if (head_cfg) begin
                    m_busy = 1; m_inflight = 1; m_drain = 0; m_rd = mq[0].word[11:7];
                end
                void'(mq.pop_front());
            end
            m_out = m_out + int'(issue) - int'(done_ok);
            m_ill = accept && !is_vec(inst);
            if (accept && is_vec(inst)) begin
                e.word = inst; e.rs1 = rs1_data; e.rs2 = rs2_data;
                mq.push_back(e);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_issue();
        test_fifo_full();
        test_cfg_drain();
        test_cfg_rd0();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
